regfile_sb: RTL and testbench

//  Parametrised multi-read register file with a per-register busy scoreboard and a sequenced clear.

---
 rtl/regfile_sb_if.sv | 31 +++
 rtl/regfile_sb.sv | 104 ++++++++++
 tb/tb_regfile_sb.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - register file access bundle: write, issue, two read ports, clear control
interface regfile_sb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_rdy1;
    logic              rd_rdy2;
    logic              clr_req;
    logic              clr_busy;

    modport master (
        output wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_addr1, rd_addr2, clr_req,
        input  rd_data1, rd_data2, rd_rdy1, rd_rdy2, clr_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_addr1, rd_addr2, clr_req,
        output rd_data1, rd_data2, rd_rdy1, rd_rdy2, clr_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-read register file with busy scoreboard and one-entry-per-cycle clear
module regfile_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    logic              in_clear;
    logic              wr_ok;
    logic              iss_ok;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_rdy  [2];

    // Writes/issues to entry 0 are dropped when it is hard-wired to zero
    assign in_clear = (state_q == S_CLEAR);
    assign wr_ok    = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    assign iss_ok   = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));

    always_comb begin
        mem_d   = mem_q;
        busy_d  = busy_q;
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == S_IDLE) begin
            if (wr_ok) begin
                mem_d[bus.wr_addr]  = bus.wr_data;
                busy_d[bus.wr_addr] = 1'b0;
            end
            // Issue is applied after the write so a new producer keeps the entry busy
            if (iss_ok) begin
                busy_d[bus.iss_addr] = 1'b1;
            end
            if (bus.clr_req) begin
                state_d = S_CLEAR;
            end
        end else begin
            mem_d[idx_q]  = '0;
            busy_d[idx_q] = 1'b0;
            idx_d         = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                state_d = S_IDLE;
            end
        end
    end

    assign rd_addr[0] = bus.rd_addr1;
    assign rd_addr[1] = bus.rd_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = mem_q[rd_addr[p]];
            rd_rdy[p]  = ~busy_q[rd_addr[p]];
            if (in_clear) begin
                rd_rdy[p] = 1'b0;
            end else if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_rdy[p]  = 1'b1;
            end else if ((BYPASS != 0) && wr_ok && (bus.wr_addr == rd_addr[p])) begin
                rd_data[p] = bus.wr_data;
                rd_rdy[p]  = 1'b1;
            end
        end
    end

    assign bus.rd_data1 = rd_data[0];
    assign bus.rd_data2 = rd_data[1];
    assign bus.rd_rdy1  = rd_rdy[0];
    assign bus.rd_rdy2  = rd_rdy[1];
    assign bus.clr_busy = in_clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    regfile_sb_if #(.DATA_W(8), .ADDR_W(3)) bif ();
    regfile_sb_if #(.DATA_W(8), .ADDR_W(3)) zif ();

    regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (zif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.wr_en = 0; bif.wr_addr = 0; bif.wr_data = 0;
        bif.iss_en = 0; bif.iss_addr = 0; bif.clr_req = 0;
        bif.rd_addr1 = 0; bif.rd_addr2 = 0;
        zif.wr_en = 0; zif.wr_addr = 0; zif.wr_data = 0;
        zif.iss_en = 0; zif.iss_addr = 0; zif.clr_req = 0;
        zif.rd_addr1 = 0; zif.rd_addr2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (bif.clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_clr_busy got=%b exp=0", bif.clr_busy);
        end
        for (int a = 0; a < 8; a++) begin
            bif.rd_addr1 = 3'(a);
            bif.rd_addr2 = 3'(a);
            #1;
            checks++;
            if (bif.rd_data1 !== 8'h00 || bif.rd_rdy1 !== 1'b1 ||
                bif.rd_data2 !== 8'h00 || bif.rd_rdy2 !== 1'b1) begin
                failures++;
                $display("FAIL reset_read a=%0d got=%h/%b %h/%b exp=00/1", a,
                         bif.rd_data1, bif.rd_rdy1, bif.rd_data2, bif.rd_rdy2);
            end
        end
    endtask

    task automatic test_write();
        tick();
        bif.wr_en = 1; bif.wr_addr = 3; bif.wr_data = 8'hA5;
        bif.rd_addr1 = 0; bif.rd_addr2 = 0;
        tick();
        bif.wr_en = 0;
        bif.rd_addr1 = 3; bif.rd_addr2 = 3;
        #1;
        checks++;
        if (bif.rd_data1 !== 8'hA5 || bif.rd_rdy1 !== 1'b1 ||
            bif.rd_data2 !== 8'hA5 || bif.rd_rdy2 !== 1'b1) begin
            failures++;
            $display("FAIL write_r3 got=%h/%b %h/%b exp=a5/1", bif.rd_data1, bif.rd_rdy1,
                     bif.rd_data2, bif.rd_rdy2);
        end
    endtask

    task automatic test_bypass();
        bif.wr_en = 1; bif.wr_addr = 5; bif.wr_data = 8'h3C;
        bif.rd_addr1 = 5; bif.rd_addr2 = 3;
        #1;
        checks++;
        if (bif.rd_data1 !== 8'h3C || bif.rd_rdy1 !== 1'b1 || bif.rd_data2 !== 8'hA5) begin
            failures++;
            $display("FAIL bypass got=%h/%b p2=%h exp=3c/1 p2=a5", bif.rd_data1, bif.rd_rdy1,
                     bif.rd_data2);
        end
        tick();
        bif.wr_en = 0;
        #1;
        checks++;
        if (bif.rd_data1 !== 8'h3C || bif.rd_rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL bypass_stored got=%h/%b exp=3c/1", bif.rd_data1, bif.rd_rdy1);
        end
    endtask

    task automatic test_issue();
        bif.iss_en = 1; bif.iss_addr = 2;
        tick();
        bif.iss_en = 0;
        bif.rd_addr1 = 2; bif.rd_addr2 = 2;
        #1;
        checks++;
        if (bif.rd_rdy1 !== 1'b0 || bif.rd_rdy2 !== 1'b0) begin
            failures++;
            $display("FAIL issue_busy got=%b/%b exp=0/0", bif.rd_rdy1, bif.rd_rdy2);
        end
        bif.wr_en = 1; bif.wr_addr = 2; bif.wr_data = 8'h11;
        tick();
        bif.wr_en = 0;
        #1;
        checks++;
        if (bif.rd_data1 !== 8'h11 || bif.rd_rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL issue_writeback got=%h/%b exp=11/1", bif.rd_data1, bif.rd_rdy1);
        end
        bif.wr_en = 1; bif.wr_addr = 2; bif.wr_data = 8'h22;
        bif.iss_en = 1; bif.iss_addr = 2;
        tick();
        bif.wr_en = 0; bif.iss_en = 0;
        #1;
        checks++;
        if (bif.rd_data1 !== 8'h22 || bif.rd_rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL issue_and_write got=%h/%b exp=22/0", bif.rd_data1, bif.rd_rdy1);
        end
    endtask

    task automatic test_clear();
        int cnt;
        for (int a = 0; a < 8; a++) begin
            bif.wr_en = 1; bif.wr_addr = 3'(a); bif.wr_data = 8'hFF;
            tick();
        end
        bif.wr_en = 0;
        bif.clr_req = 1;
        #1;
        checks++;
        if (bif.clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_busy_early got=%b exp=0", bif.clr_busy);
        end
        tick();
        bif.clr_req = 0;
        bif.wr_en = 1; bif.wr_addr = 6; bif.wr_data = 8'h55;
        bif.rd_addr1 = 7;
        #1;
        checks++;
        if (bif.rd_data1 !== 8'hFF || bif.rd_rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL clear_read got=%h/%b exp=ff/0", bif.rd_data1, bif.rd_rdy1);
        end
        cnt = 0;
        while (bif.clr_busy === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        bif.wr_en = 0;
        checks++;
        if (cnt != 8) begin
            failures++;
            $display("FAIL clear_duration got=%0d exp=8", cnt);
        end
        for (int a = 0; a < 8; a++) begin
            bif.rd_addr1 = 3'(a);
            bif.rd_addr2 = 3'(7 - a);
            #1;
            checks++;
            if (bif.rd_data1 !== 8'h00 || bif.rd_rdy1 !== 1'b1 ||
                bif.rd_data2 !== 8'h00 || bif.rd_rdy2 !== 1'b1) begin
                failures++;
                $display("FAIL clear_after a=%0d got=%h/%b %h/%b exp=00/1", a,
                         bif.rd_data1, bif.rd_rdy1, bif.rd_data2, bif.rd_rdy2);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        bif.wr_en = 1; bif.wr_addr = 1; bif.wr_data = 8'h12;
        tick();
        bif.wr_addr = 6; bif.wr_data = 8'h34;
        tick();
        bif.wr_en = 0;
        bif.iss_en = 1; bif.iss_addr = 4;
        tick();
        bif.iss_en = 0;
        bif.clr_req = 1;
        tick();
        bif.clr_req = 0;
        repeat (3) tick();
        checks++;
        if (bif.clr_busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_4th_cycle got=%b exp=1", bif.clr_busy);
        end
        reset = 1;
        #1;
        checks++;
        if (bif.clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got=%b exp=0", bif.clr_busy);
        end
        for (int a = 0; a < 8; a++) begin
            bif.rd_addr1 = 3'(a);
            #1;
            checks++;
            if (bif.rd_data1 !== 8'h00 || bif.rd_rdy1 !== 1'b1) begin
                failures++;
                $display("FAIL reset_abort_read a=%0d got=%h/%b exp=00/1", a,
                         bif.rd_data1, bif.rd_rdy1);
            end
        end
        @(negedge clk);
        reset = 0;
        tick();
        checks++;
        if (bif.clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_stays got=%b exp=0", bif.clr_busy);
        end
    endtask

    task automatic test_zero_reg();
        zif.wr_en = 1; zif.wr_addr = 0; zif.wr_data = 8'h77;
        zif.rd_addr1 = 0;
        #1;
        checks++;
        if (zif.rd_data1 !== 8'h00 || zif.rd_rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL zero_bypass got=%h/%b exp=00/1", zif.rd_data1, zif.rd_rdy1);
        end
        tick();
        zif.wr_addr = 1;
        zif.iss_en = 1; zif.iss_addr = 0;
        tick();
        zif.wr_en = 0; zif.iss_en = 0;
        zif.rd_addr2 = 1;
        #1;
        checks++;
        if (zif.rd_data1 !== 8'h00 || zif.rd_rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL zero_r0 got=%h/%b exp=00/1", zif.rd_data1, zif.rd_rdy1);
        end
        checks++;
        if (zif.rd_data2 !== 8'h77 || zif.rd_rdy2 !== 1'b1) begin
            failures++;
            $display("FAIL zero_r1 got=%h/%b exp=77/1", zif.rd_data2, zif.rd_rdy2);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 0;
        test_reset();
        test_write();
        test_bypass();
        test_issue();
        test_clear();
        test_reset_mid_clear();
        test_zero_reg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
